// File: rtl/j_audio_pkg.sv
// Shared audio constants: default slot width, word-select encodings and
// frame/counter sizing used by the I2S transmitter.
package j_audio_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    localparam int FRAME_LEN = 2 * WIDTH_DEF;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    function automatic int frame_len(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/j_i2s_tx_if.sv
// DSP-side bus of the I2S transmitter: sample load handshake, pacing strobes,
// serial outputs and underrun flag.
import j_audio_pkg::*;

interface j_i2s_tx_if #(
    parameter int WIDTH = WIDTH_DEF
);
    logic             en;
    logic             sck_en;
    logic             ld;
    logic [WIDTH-1:0] din_l;
    logic [WIDTH-1:0] din_r;
    logic             ldreq;
    logic             sdata;
    logic             ws;
    logic             underrun;
    logic             underrun_clr;

    modport master (
        output en, sck_en, ld, din_l, din_r, underrun_clr,
        input  ldreq, sdata, ws, underrun
    );

    modport slave (
        input  en, sck_en, ld, din_l, din_r, underrun_clr,
        output ldreq, sdata, ws, underrun
    );
endinterface

// File: rtl/j_i2s_hold.sv
// One-deep holding buffer for a left/right sample pair with the ld handshake.
import j_audio_pkg::*;

module j_i2s_hold #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               ld,
    input  logic [WIDTH-1:0]   din_l,
    input  logic [WIDTH-1:0]   din_r,
    input  logic               take,
    output logic [2*WIDTH-1:0] hold_word,
    output logic               hold_valid
);

    // A load while full is accepted only if the serializer drains the old pair
    // in the same cycle.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            hold_word  <= '0;
            hold_valid <= 1'b0;
        end else begin
            if (take)
                hold_valid <= 1'b0;
            if (ld && (!hold_valid || take)) begin
                hold_word  <= {din_l, din_r};
                hold_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/j_i2s_tx.sv
// I2S transmitter: frame counter, MSB-first shift register and WS generation.
// Optional macro J_I2S_TX_UNDERRUN_EN enables the sticky underrun flag.
import j_audio_pkg::*;

module j_i2s_tx #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic        sys_clk,
    input  logic        reset,
    j_i2s_tx_if.slave   bus
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int CW    = $clog2(FRAME);

    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_next;
    logic [FRAME-1:0]   shreg;
    logic [FRAME-1:0]   hold_word;
    logic [FRAME-1:0]   frame_word;
    logic               hold_valid;
    logic               sdata_q;
    logic               ws_q;
    logic               ws_next;
    logic               start;
    logic               take;

    assign start = bus.en && bus.sck_en && (cnt == '0);
    assign take  = start && hold_valid;

    j_i2s_hold #(.WIDTH(WIDTH)) u_hold (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .ld         (bus.ld),
        .din_l      (bus.din_l),
        .din_r      (bus.din_r),
        .take       (take),
        .hold_word  (hold_word),
        .hold_valid (hold_valid)
    );

    always_comb begin
        cnt_next   = (cnt == CW'(FRAME - 1)) ? '0 : cnt + 1'b1;
        // WS changes one strobe before the slot it names, giving the I2S lead.
        ws_next    = (cnt_next >= CW'(WIDTH)) ? WS_RIGHT : WS_LEFT;
        frame_word = hold_valid ? hold_word : '0;
    end

    always_ff @(posedge sys_clk) begin
        if (reset || !bus.en) begin
            cnt     <= '0;
            shreg   <= '0;
            sdata_q <= 1'b0;
            ws_q    <= WS_LEFT;
        end else if (bus.sck_en) begin
            if (cnt == '0) begin
                sdata_q <= frame_word[FRAME-1];
                shreg   <= {frame_word[FRAME-2:0], 1'b0};
            end else begin
                sdata_q <= shreg[FRAME-1];
                shreg   <= {shreg[FRAME-2:0], 1'b0};
            end
            ws_q <= ws_next;
            cnt  <= cnt_next;
        end
    end

`ifdef J_I2S_TX_UNDERRUN_EN
    logic underrun_q;

    // A new underrun takes priority over a simultaneous clear.
    always_ff @(posedge sys_clk) begin
        if (reset)
            underrun_q <= 1'b0;
        else if (start && !hold_valid)
            underrun_q <= 1'b1;
        else if (bus.underrun_clr)
            underrun_q <= 1'b0;
    end

    assign bus.underrun = underrun_q;
`else
    assign bus.underrun = 1'b0;
`endif

    assign bus.ldreq = ~hold_valid;
    assign bus.sdata = sdata_q;
    assign bus.ws    = ws_q;

endmodule

// File: tb/tb_j_i2s_tx.sv
// Directed bench for j_i2s_tx: reset, empty frames, data frames, load
// collisions, enable drop and underrun flag behaviour.
module tb_j_i2s_tx;

    logic sys_clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] WS_PATTERN = 32'h0001_FFFE;

    j_i2s_tx_if #(.WIDTH(16)) bus ();

    j_i2s_tx #(.WIDTH(16)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] l, input logic [15:0] r);
        bus.ld    = 1'b1;
        bus.din_l = l;
        bus.din_r = r;
        tick();
        bus.ld    = 1'b0;
    endtask

    // Runs 32 strobes; bit k of the frame (MSB first) lands in sd[31-k].
    task automatic run_frame(input int gap, input bit ld_start,
                             input logic [15:0] l, input logic [15:0] r,
                             output logic [31:0] sd, output logic [31:0] wsv,
                             output logic rq);
        sd  = '0;
        wsv = '0;
        rq  = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == 0 && ld_start) begin
                bus.ld    = 1'b1;
                bus.din_l = l;
                bus.din_r = r;
            end
            bus.sck_en = 1'b1;
            tick();
            bus.ld     = 1'b0;
            bus.sck_en = 1'b0;
            sd[31-k]  = bus.sdata;
            wsv[31-k] = bus.ws;
            if (k == 0)
                rq = bus.ldreq;
            repeat (gap) tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checks++; if (bus.ldreq !== 1'b1) begin failures++; $display("FAIL reset_ldreq got=%b exp=1", bus.ldreq); end
        checks++; if (bus.sdata !== 1'b0) begin failures++; $display("FAIL reset_sdata got=%b exp=0", bus.sdata); end
        checks++; if (bus.ws !== 1'b0) begin failures++; $display("FAIL reset_ws got=%b exp=0", bus.ws); end
        checks++; if (bus.underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", bus.underrun); end
    endtask

    task automatic test_empty_frame();
        logic [31:0] sd, wsv;
        logic        rq;
        logic        exp_ur;
`ifdef J_I2S_TX_UNDERRUN_EN
        exp_ur = 1'b1;
`else
        exp_ur = 1'b0;
`endif
        bus.en = 1'b1;
        run_frame(1, 1'b0, 16'h0, 16'h0, sd, wsv, rq);
        checks++; if (sd !== 32'h0) begin failures++; $display("FAIL empty_sdata got=%h exp=00000000", sd); end
        checks++; if (wsv !== WS_PATTERN) begin failures++; $display("FAIL empty_ws got=%h exp=%h", wsv, WS_PATTERN); end
        checks++; if (bus.underrun !== exp_ur) begin failures++; $display("FAIL empty_underrun got=%b exp=%b", bus.underrun, exp_ur); end
        bus.underrun_clr = 1'b1;
        tick();
        bus.underrun_clr = 1'b0;
        checks++; if (bus.underrun !== 1'b0) begin failures++; $display("FAIL underrun_clr got=%b exp=0", bus.underrun); end
    endtask

    task automatic test_frame();
        logic [31:0] sd, wsv;
        logic        rq;
        do_load(16'hA5C3, 16'h0F0F);
        checks++; if (bus.ldreq !== 1'b0) begin failures++; $display("FAIL load_ldreq got=%b exp=0", bus.ldreq); end
        run_frame(2, 1'b0, 16'h0, 16'h0, sd, wsv, rq);
        checks++; if (rq !== 1'b1) begin failures++; $display("FAIL frame_ldreq got=%b exp=1", rq); end
        checks++; if (sd !== 32'hA5C3_0F0F) begin failures++; $display("FAIL frame_sdata got=%h exp=a5c30f0f", sd); end
        checks++; if (wsv !== WS_PATTERN) begin failures++; $display("FAIL frame_ws got=%h exp=%h", wsv, WS_PATTERN); end
        checks++; if (bus.underrun !== 1'b0) begin failures++; $display("FAIL frame_underrun got=%b exp=0", bus.underrun); end
    endtask

    task automatic test_ld_full();
        logic [31:0] sd, wsv;
        logic        rq;
        do_load(16'hA5C3, 16'h0F0F);
        do_load(16'h1234, 16'h5678);
        checks++; if (bus.ldreq !== 1'b0) begin failures++; $display("FAIL full_ldreq got=%b exp=0", bus.ldreq); end
        run_frame(0, 1'b0, 16'h0, 16'h0, sd, wsv, rq);
        checks++; if (sd !== 32'hA5C3_0F0F) begin failures++; $display("FAIL full_sdata got=%h exp=a5c30f0f", sd); end
        checks++; if (wsv !== WS_PATTERN) begin failures++; $display("FAIL b2b_ws got=%h exp=%h", wsv, WS_PATTERN); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sd, wsv;
        logic        rq;
        do_load(16'hA5C3, 16'h0F0F);
        run_frame(1, 1'b1, 16'hFFFF, 16'h0000, sd, wsv, rq);
        checks++; if (rq !== 1'b0) begin failures++; $display("FAIL collide_ldreq got=%b exp=0", rq); end
        checks++; if (sd !== 32'hA5C3_0F0F) begin failures++; $display("FAIL collide_sdata got=%h exp=a5c30f0f", sd); end
        run_frame(1, 1'b0, 16'h0, 16'h0, sd, wsv, rq);
        checks++; if (sd !== 32'hFFFF_0000) begin failures++; $display("FAIL collide_next got=%h exp=ffff0000", sd); end
        checks++; if (rq !== 1'b1) begin failures++; $display("FAIL collide_next_ldreq got=%b exp=1", rq); end
    endtask

    task automatic test_en_drop();
        logic [31:0] sd, wsv;
        logic        rq;
        do_load(16'hFFFF, 16'hFFFF);
        for (int k = 0; k < 20; k++) begin
            bus.sck_en = 1'b1;
            tick();
            bus.sck_en = 1'b0;
        end
        checks++; if (bus.sdata !== 1'b1 || bus.ws !== 1'b1) begin failures++; $display("FAIL predrop_out got=%b%b exp=11", bus.sdata, bus.ws); end
        do_load(16'hC001, 16'h8000);
        bus.en     = 1'b0;
        bus.sck_en = 1'b1;
        tick();
        bus.sck_en = 1'b0;
        checks++; if (bus.sdata !== 1'b0) begin failures++; $display("FAIL drop_sdata got=%b exp=0", bus.sdata); end
        checks++; if (bus.ws !== 1'b0) begin failures++; $display("FAIL drop_ws got=%b exp=0", bus.ws); end
        checks++; if (bus.ldreq !== 1'b0) begin failures++; $display("FAIL drop_hold got=%b exp=0", bus.ldreq); end
        tick();
        bus.en = 1'b1;
        run_frame(1, 1'b0, 16'h0, 16'h0, sd, wsv, rq);
        checks++; if (sd !== 32'hC001_8000) begin failures++; $display("FAIL reenable_sdata got=%h exp=c0018000", sd); end
        checks++; if (wsv !== WS_PATTERN) begin failures++; $display("FAIL reenable_ws got=%h exp=%h", wsv, WS_PATTERN); end
    endtask

    task automatic test_underrun_priority();
        logic exp_ur;
`ifdef J_I2S_TX_UNDERRUN_EN
        exp_ur = 1'b1;
`else
        exp_ur = 1'b0;
`endif
        bus.underrun_clr = 1'b1;
        bus.sck_en       = 1'b1;
        tick();
        bus.sck_en       = 1'b0;
        bus.underrun_clr = 1'b0;
        checks++; if (bus.underrun !== exp_ur) begin failures++; $display("FAIL set_wins got=%b exp=%b", bus.underrun, exp_ur); end
        checks++; if (bus.sdata !== 1'b0) begin failures++; $display("FAIL zero_fill got=%b exp=0", bus.sdata); end
        bus.underrun_clr = 1'b1;
        tick();
        bus.underrun_clr = 1'b0;
        checks++; if (bus.underrun !== 1'b0) begin failures++; $display("FAIL final_clr got=%b exp=0", bus.underrun); end
    endtask

    initial begin
        reset            = 1'b1;
        bus.en           = 1'b0;
        bus.sck_en       = 1'b0;
        bus.ld           = 1'b0;
        bus.din_l        = '0;
        bus.din_r        = '0;
        bus.underrun_clr = 1'b0;
        test_reset();
        test_empty_frame();
        test_frame();
        test_ld_full();
        test_back_to_back();
        test_en_drop();
        test_underrun_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/j_i2s_tx.md
# j_i2s_tx

Serial audio transmitter for Jerry's synchronous serial port: the transmit counterpart of the synchronous capture registers on the receive side. The DSP writes a left/right sample pair into a one-deep holding buffer. The block moves each pair into a shift register at frame start and drives it out MSB-first in I2S format. Word select leads data by one bit, and all shifting is paced by a serial-clock enable strobe.

## Interface
- `WIDTH`, 16, bits per channel slot; frame length is 2*WIDTH strobes.
- `sys_clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  transmitter enable; low holds the serializer idle.
- `sck_en`  in  1  one-cycle strobe marking each serial-clock falling edge (shift point).
- `ld`  in  1  load strobe for `din_l`/`din_r`.
- `din_l`  in  WIDTH  left sample.
- `din_r`  in  WIDTH  right sample.
- `ldreq`  out  1  holding buffer empty; ready for `ld`.
- `sdata`  out  1  serial data.
- `ws`  out  1  word select: 0 = left, 1 = right.
- `underrun`  out  1  sticky flag: frame started with an empty buffer.
- `underrun_clr`  in  1  clears `underrun`.

## Operation
- Reset: `cnt`=0, shift register=0, hold=0, `hold_valid`=0, `sdata`=0, `ws`=0, `underrun`=0. `ldreq` therefore reads 1.
- Holding buffer:
  - `ld` while `hold_valid`=0: latch `{din_l,din_r}` and set `hold_valid`.
  - `ld` while full: ignored; buffer contents are unchanged.
  - `ldreq` = ~`hold_valid`.
- Serializer: acts only on a cycle with `en`=1 and `sck_en`=1. `c` is the current `cnt`, range 0..2*WIDTH-1.
  - c==0 (frame start):
    - Word W = `{hold_l,hold_r}` if `hold_valid`, else all zeros.
    - `sdata` <= W[MSB]; shift register <= W<<1.
    - If data was taken, clear `hold_valid`. If not, set `underrun`.
  - c!=0: `sdata` <= shift register MSB; shift register <<= 1.
  - `ws` <= 1 when ((c+1) mod 2*WIDTH) >= WIDTH, else 0. `ws` rises at c=WIDTH-1 and falls at c=2*WIDTH-1, giving the I2S one-bit lead.
  - `cnt` <= (c+1) mod 2*WIDTH.
- `ld` and a frame-start transfer in the same cycle while full: the transfer takes the old pair and `ld` is accepted. `hold_valid` stays 1 with the new pair.
- `en`=0: same cycle as the enable drop, `cnt`, `sdata`, `ws` and the shift register go to 0. A mid-frame deassert abandons the frame. The holding buffer and `underrun` are retained. On re-enable, the first strobe is a frame start.
- `underrun_clr` and a new underrun in the same cycle: set wins.

## Timing
- `ld` to `ldreq`=0: 1 cycle.
- Frame-start strobe to `ldreq`=1: 1 cycle.
- Strobe to `sdata`/`ws` update: 1 cycle (registered outputs).
- `sck_en` must be no more frequent than every cycle. Back-to-back strobes are legal.
- `reset` overrides everything, including mid-frame operation.

## Configuration
- `J_I2S_TX_UNDERRUN_EN` defined: the `underrun` sticky flag and `underrun_clr` behave as specified above.
- Not defined: `underrun` is tied to 0 and `underrun_clr` is ignored. Zero-fill on an empty buffer is unchanged.

## Structure
- Shared package `j_audio_pkg` holds:
  - the default `WIDTH`;
  - the `WS_LEFT`/`WS_RIGHT` encodings;
  - a frame-length helper constant (2*WIDTH) and the `cnt` width (clog2 of 2*WIDTH).
- One sub-module, `j_i2s_hold`, implements the holding buffer and the `ld` handshake. The top module contains the counter, shift register and flags.

## Test plan
- Reset, then `en`=1 with no `ld` for 32 strobes: `sdata` is all 0; `ws` toggles 0→1 after strobe 15 and 1→0 after strobe 31; `underrun`=1 (macro on).
- `ld` with L=0xA5C3, R=0x0F0F before the first strobe: `sdata` sequence over 32 strobes is 1010010111000011 then 0000111100001111. `ldreq` returns to 1 one cycle after the frame-start strobe.
- Second `ld` while full (L=0x1234): ignored; the next frame still sends the first pair's data.
- `ld` (L=0xFFFF) in the same cycle as the frame-start transfer of 0xA5C3: 0xA5C3 is sent; `ldreq` stays 0; the following frame sends 0xFFFF.
- `en` dropped at strobe 7: `sdata`=`ws`=0 next cycle. After re-enable, the first bit out is the MSB of the held pair.
- Macro off, empty-buffer frame: zeros sent; `underrun` stays 0. Macro on: `underrun_clr` clears the flag one cycle later.
